hv_serializer: RTL and testbench

Output-side serializer for the HPU result path. Accepts full-width encoded hypervectors as single-cycle `stream_v`/`stream_d` pulses from the bundling/sign stage. Buffers them in a two-entry ping-pong store and drains each as a sequence of narrow AXI-Stream beats toward the DMA/ACP write channel. Raises `tlast` on the final beat of a batch and flags overruns, because the producer has no backpressure input.

---
 rtl/hpu_pkg.sv | 23 ++
 rtl/hv_pingpong.sv | 81 ++++++++
 rtl/hv_serializer.sv | 104 ++++++++++
 tb/tb_hv_serializer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hpu_pkg.sv
// -----------------------------------------------------------------------------
// hpu_pkg
// Shared constants and types for the HPU result path.
//   HV_W        : width of one encoded hypervector
//   AXIS_W      : AXI-Stream beat width toward the DMA/ACP write channel
//   BEATS       : beats needed to carry one hypervector
//   hv_t        : one full-width hypervector
//   ser_state_t : drain FSM states of hv_serializer
// -----------------------------------------------------------------------------
package hpu_pkg;

    localparam int HV_W   = 1024;
    localparam int AXIS_W = 64;
    localparam int BEATS  = HV_W / AXIS_W;

    typedef logic [HV_W-1:0] hv_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

endpackage

// File: rtl/hv_pingpong.sv
// -----------------------------------------------------------------------------
// hv_pingpong
// Two-entry ping-pong store for full-width hypervectors plus their batch-last
// flag. Tracks write/read pointers and occupancy, flags overruns.
// Ports:
//   clk, rst          : clock, synchronous active-low reset
//   wr_en             : producer strobe (no backpressure available upstream)
//   wr_data, wr_last  : hypervector and its end-of-batch flag
//   rd_done           : consumer finished the entry at the read pointer
//   rd_data, rd_last  : entry at the read pointer
//   cnt               : occupancy, 0..2
//   wr_accept         : strobe is being stored this cycle
//   full              : both entries occupied
//   overrun           : sticky, a strobe was dropped
// -----------------------------------------------------------------------------
module hv_pingpong
    import hpu_pkg::*;
#(
    parameter int DATA_W = HV_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    input  logic              rd_done,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic [1:0]        cnt,
    output logic              wr_accept,
    output logic              full,
    output logic              overrun
);

    logic [DATA_W:0] mem [2];
    logic            wp;
    logic            rp;

    // A full store can still take a strobe when the oldest entry frees up in
    // the same cycle; the slot being drained is exactly the one wp points at.
    assign wr_accept = wr_en && ((cnt != 2'd2) || rd_done);
    assign full      = (cnt == 2'd2);

    assign rd_data = mem[rp][DATA_W-1:0];
    assign rd_last = mem[rp][DATA_W];

    // NOTE: the storage array has no reset; occupancy and pointers decide what
    // is valid, so clearing 2x(DATA_W+1) flops would buy nothing.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wp] <= {wr_last, wr_data};
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // sees the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wp      <= 1'b0;
            rp      <= 1'b0;
            cnt     <= 2'd0;
            overrun <= 1'b0;
        end else begin
            if (wr_accept) begin
                wp <= ~wp;
            end
            if (rd_done) begin
                rp <= ~rp;
            end
            if (wr_en && !wr_accept) begin
                overrun <= 1'b1;
            end
            case ({wr_accept, rd_done})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/hv_serializer.sv
// -----------------------------------------------------------------------------
// hv_serializer
// Buffers full-width hypervectors in a ping-pong store and drains each as a
// sequence of W-bit AXI-Stream beats, least significant word first.
// Ports:
//   clk, rst                 : clock, synchronous active-low reset
//   stream_v/d/last          : single-cycle hypervector strobe from the
//                              bundling/sign stage; last marks end of batch
//   m_axis_tvalid/tready     : AXI-Stream handshake
//   m_axis_tdata             : beat data
//   m_axis_tlast             : final beat of a batch-final hypervector
//   buf_full                 : both entries occupied
//   overrun                  : sticky, a strobe was dropped
// -----------------------------------------------------------------------------
module hv_serializer
    import hpu_pkg::*;
#(
    parameter int DIM = HV_W - 1,
    parameter int W   = AXIS_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stream_v,
    input  logic [DIM:0] stream_d,
    input  logic         stream_last,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    output logic [W-1:0] m_axis_tdata,
    output logic         m_axis_tlast,
    output logic         buf_full,
    output logic         overrun
);

    localparam int N_BEATS = (DIM + 1) / W;
    localparam int BEAT_W  = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_BEATS - 1);

    ser_state_t        state;
    logic [BEAT_W-1:0] beat;
    logic [DIM:0]      rd_data;
    logic              rd_last;
    logic [1:0]        cnt;
    logic              wr_accept;
    logic              handshake;
    logic              final_hs;

    assign handshake = m_axis_tvalid && m_axis_tready;
    assign final_hs  = handshake && (beat == LAST_BEAT);

    hv_pingpong #(
        .DATA_W (DIM + 1)
    ) u_store (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (stream_v),
        .wr_data   (stream_d),
        .wr_last   (stream_last),
        .rd_done   (final_hs),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .cnt       (cnt),
        .wr_accept (wr_accept),
        .full      (buf_full),
        .overrun   (overrun)
    );

    // tvalid is the registered SEND state. tdata/tlast are selected from
    // registered storage by registered beat/rp, so they cannot change while
    // a beat is stalled.
    assign m_axis_tvalid = (state == SEND);
    assign m_axis_tdata  = m_axis_tvalid ? rd_data[int'(beat)*W +: W] : '0;
    assign m_axis_tlast  = m_axis_tvalid && (beat == LAST_BEAT) && rd_last;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            beat  <= '0;
        end else begin
            case (state)
                // Leaving on the capture itself gives the first beat one
                // cycle after the strobe instead of two.
                IDLE: begin
                    if ((cnt != 2'd0) || wr_accept) begin
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (final_hs) begin
                        beat <= '0;
                        // Another entry remains if the store was full, or a
                        // new vector lands in the same cycle.
                        if (!((cnt == 2'd2) || wr_accept)) begin
                            state <= IDLE;
                        end
                    end else if (handshake) begin
                        beat <= beat + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hv_serializer.sv
module tb_hv_serializer;

    localparam int DIM   = 1023;
    localparam int W     = 64;
    localparam int BEATS = (DIM + 1) / W;

    typedef struct {
        logic [DIM:0] d;
        logic         l;
    } ent_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         stream_v = 1'b0;
    logic [DIM:0] stream_d = '0;
    logic         stream_last = 1'b0;
    logic         m_axis_tvalid;
    logic         m_axis_tready = 1'b0;
    logic [W-1:0] m_axis_tdata;
    logic         m_axis_tlast;
    logic         buf_full;
    logic         overrun;

    always #5 clk = ~clk;

    hv_serializer #(
        .DIM (DIM),
        .W   (W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stream_v      (stream_v),
        .stream_d      (stream_d),
        .stream_last   (stream_last),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .buf_full      (buf_full),
        .overrun       (overrun)
    );

    // Reference model: a queue of accepted hypervectors, a beat index into
    // the head, and a sticky overrun flag.
    ent_t q[$];
    int   m_beat   = 0;
    bit   m_ovr    = 1'b0;
    int   hs_count = 0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DIM:0] pattern_hv();
        logic [DIM:0] v;
        for (int k = 0; k < BEATS; k++) begin
            logic [7:0] b;
            b = 8'(k);
            v[k*W +: W] = {8{b}};
        end
        return v;
    endfunction

    function automatic logic [DIM:0] rand_hv();
        logic [DIM:0] v;
        for (int i = 0; i < (DIM + 1) / 32; i++) begin
            v[i*32 +: 32] = $urandom();
        end
        return v;
    endfunction

    // One clock: advance the model at the rising edge from the inputs the
    // bench is driving, then compare every output mid-cycle.
    task automatic tick();
        bit hs, fin, acc;
        @(posedge clk);
        if (!rst) begin
            q.delete();
            m_beat = 0;
            m_ovr  = 1'b0;
        end else begin
            hs  = (q.size() > 0) && m_axis_tready;
            fin = hs && (m_beat == BEATS - 1);
            acc = stream_v && ((q.size() < 2) || fin);
            if (hs) hs_count++;
            if (stream_v && !acc) m_ovr = 1'b1;
            if (fin) begin
                void'(q.pop_front());
                m_beat = 0;
            end else if (hs) begin
                m_beat++;
            end
            if (acc) q.push_back('{d: stream_d, l: stream_last});
        end
        @(negedge clk);
        check("tvalid", 64'(m_axis_tvalid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            check("tdata", m_axis_tdata, q[0].d[m_beat*W +: W]);
        end
        check("tlast", 64'(m_axis_tlast),
              64'((q.size() > 0) && (m_beat == BEATS - 1) && q[0].l));
        check("buf_full", 64'(buf_full), 64'(q.size() == 2));
        check("overrun", 64'(overrun), 64'(m_ovr));
    endtask

    task automatic strobe(input logic [DIM:0] d, input logic l);
        stream_v    = 1'b1;
        stream_d    = d;
        stream_last = l;
        tick();
        stream_v    = 1'b0;
        stream_last = 1'b0;
    endtask

    task automatic drain(input int budget);
        m_axis_tready = 1'b1;
        for (int i = 0; i < budget && q.size() > 0; i++) tick();
        check("drain_timeout", 64'(q.size()), 64'd0);
        check("drain_idle", 64'(m_axis_tvalid), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        logic [DIM:0] va;
        logic [DIM:0] vb;

        // Reset state
        rst = 1'b0;
        tick();
        tick();
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tdata", m_axis_tdata, 64'd0);
        check("rst_tlast", 64'(m_axis_tlast), 64'd0);
        check("rst_full", 64'(buf_full), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        rst = 1'b1;
        tick();

        // Single vector: first beat the cycle after the strobe, LSW first
        m_axis_tready = 1'b1;
        strobe(pattern_hv(), 1'b1);
        check("sv_first_valid", 64'(m_axis_tvalid), 64'd1);
        check("sv_beat0", m_axis_tdata, 64'h0000000000000000);
        tick();
        check("sv_beat1", m_axis_tdata, 64'h0101010101010101);
        for (int i = 0; i < 14; i++) tick();
        check("sv_beat15", m_axis_tdata, 64'h0F0F0F0F0F0F0F0F);
        check("sv_tlast15", 64'(m_axis_tlast), 64'd1);
        tick();
        check("sv_done", 64'(m_axis_tvalid), 64'd0);

        // Backpressure: tready 1,0,0 repeating
        m_axis_tready = 1'b1;
        hs_count = 0;
        strobe(pattern_hv(), 1'b1);
        for (int i = 0; i < 200 && q.size() > 0; i++) begin
            m_axis_tready = (i % 3 == 0);
            tick();
        end
        check("bp_beats", 64'(hs_count), 64'(BEATS));
        drain(10);

        // Back-to-back A (last=0), B (last=1) strobed BEATS cycles apart
        va = rand_hv();
        vb = rand_hv();
        m_axis_tready = 1'b1;
        strobe(va, 1'b0);
        for (int i = 0; i < BEATS - 1; i++) tick();
        check("b2b_a_last_beat", m_axis_tdata, va[DIM -: W]);
        strobe(vb, 1'b1);
        check("b2b_b_beat0", m_axis_tdata, vb[W-1:0]);
        check("b2b_no_bubble", 64'(m_axis_tvalid), 64'd1);
        drain(40);

        // Full / overrun
        m_axis_tready = 1'b0;
        strobe(rand_hv(), 1'b0);
        strobe(rand_hv(), 1'b1);
        check("ov_full", 64'(buf_full), 64'd1);
        strobe(rand_hv(), 1'b1);
        check("ov_flag", 64'(overrun), 64'd1);
        hs_count = 0;
        drain(100);
        check("ov_beats", 64'(hs_count), 64'(2 * BEATS));
        check("ov_sticky", 64'(overrun), 64'd1);
        do_reset();
        check("ov_cleared", 64'(overrun), 64'd0);

        // Simultaneous capture and final-beat drain while full
        m_axis_tready = 1'b0;
        strobe(rand_hv(), 1'b0);
        strobe(rand_hv(), 1'b0);
        m_axis_tready = 1'b1;
        for (int i = 0; i < BEATS - 1; i++) tick();
        va = rand_hv();
        strobe(va, 1'b1);
        check("sim_overrun", 64'(overrun), 64'd0);
        check("sim_full", 64'(buf_full), 64'd1);
        drain(60);

        // Reset mid-drain during beat 7
        m_axis_tready = 1'b1;
        strobe(rand_hv(), 1'b1);
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b0;
        tick();
        check("mid_rst_valid", 64'(m_axis_tvalid), 64'd0);
        check("mid_rst_tdata", m_axis_tdata, 64'd0);
        check("mid_rst_full", 64'(buf_full), 64'd0);
        rst = 1'b1;
        tick();
        vb = rand_hv();
        strobe(vb, 1'b0);
        check("mid_rst_restart", m_axis_tdata, vb[W-1:0]);
        drain(30);

        // Randomized traffic, including occasional producer-rule violations
        for (int i = 0; i < 3000; i++) begin
            m_axis_tready = ($urandom_range(0, 3) != 0);
            stream_v      = ($urandom_range(0, 13) == 0);
            stream_d      = rand_hv();
            stream_last   = $urandom_range(0, 1);
            tick();
        end
        stream_v    = 1'b0;
        stream_last = 1'b0;
        drain(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
